// File: rtl/avmm_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : avmm_pkg
// Brief   : Shared types, LFSR constants and helpers for the AVMM memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package avmm_pkg;

    localparam int c_LFSR_W = 16;
    // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [c_LFSR_W-1:0] c_LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_ISSUE = 2'd2
    } avmm_rsp_state_t;

    function automatic int burst_bits(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, v} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : lfsr16
// Brief   : 16-bit Fibonacci LFSR with synchronous reset to a seed value.
// Revision: 1.0 - initial release
// ============================================================================
module lfsr16
    import avmm_pkg::*;
#(
    parameter logic [c_LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic [c_LFSR_W-1:0] q
);

    logic [c_LFSR_W-1:0] r_q;
    logic                w_fb;

    assign w_fb = ^(r_q & c_LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= SEED;
        end else if (en) begin
            r_q <= {w_fb, r_q[c_LFSR_W-1:1]};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/avmm_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : avmm_mem_responder
// Brief   : Memory-backed Avalon-MM slave with bursts, read latency pipeline,
//           optional LFSR waitrequest stalls and saturating event counters.
// Revision: 1.0 - initial release
// ============================================================================
module avmm_mem_responder
    import avmm_pkg::*;
#(
    parameter int          AW        = 10,
    parameter int          DW        = 32,
    parameter int          MAX_BURST = 1,
    parameter int          DEPTH     = 1024,
    parameter int          RD_LAT    = 2,
    parameter int          WAIT_MODE = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         BW        = burst_bits(MAX_BURST)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   avm_address,
    input  logic            avm_read,
    input  logic            avm_write,
    input  logic [DW-1:0]   avm_writedata,
    input  logic [DW/8-1:0] avm_byteenable,
    input  logic [BW-1:0]   avm_burstcount,
    output logic            avm_waitrequest,
    output logic [DW-1:0]   avm_readdata,
    output logic            avm_readdatavalid,
    input  logic            stall_en,
    output logic [15:0]     wr_beats,
    output logic [15:0]     rd_beats,
    output logic [15:0]     err_cnt
);

    localparam int c_IW = $clog2(DEPTH);
    localparam int c_NB = DW / 8;

    localparam logic [1:0] c_ST_IDLE     = IDLE;
    localparam logic [1:0] c_ST_WR_BURST = WR_BURST;
    localparam logic [1:0] c_ST_RD_ISSUE = RD_ISSUE;

    localparam logic [c_IW-1:0] c_IDX_ONE = 1;
    localparam logic [BW-1:0]   c_LEN_ONE = 1;
    localparam logic [BW-1:0]   c_MAX_LEN = MAX_BURST[BW-1:0];

    logic [1:0]        r_state,   w_state_nxt;
    logic [c_IW-1:0]   r_idx,     w_idx_nxt;
    logic [BW-1:0]     r_left,    w_left_nxt;
    logic [15:0]       r_wr_beats, r_rd_beats, r_err_cnt;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [DW-1:0]     r_pipe_dat [RD_LAT];

    logic [15:0]       w_lfsr;
    logic              w_stall;
    logic              w_wait;
    logic              w_accept;
    logic              w_bc_bad;
    logic [BW-1:0]     w_len;
    logic [c_IW-1:0]   w_cmd_idx;
    logic              w_we;
    logic [c_IW-1:0]   w_we_idx;
    logic              w_issue;
    logic [c_IW-1:0]   w_rd_idx;
    logic [DW-1:0]     w_rd_word;
    logic [1:0]        w_err_inc;
    logic              w_unused;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (w_lfsr)
    );

    assign w_stall   = (WAIT_MODE == 1) ? (stall_en & w_lfsr[0]) : 1'b0;
    assign w_cmd_idx = avm_address[c_IW-1:0];
    assign w_bc_bad  = (avm_burstcount == '0) || (avm_burstcount > c_MAX_LEN);
    assign w_len     = w_bc_bad ? c_LEN_ONE : avm_burstcount;
    assign w_accept  = (r_state == c_ST_IDLE) && (avm_read || avm_write) && !w_wait;

    always_comb begin
        w_wait = 1'b1;
        if (!rst) begin
            case (r_state)
                c_ST_IDLE, c_ST_WR_BURST: w_wait = w_stall;
                default:                  w_wait = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_left_nxt  = r_left;
        w_we        = 1'b0;
        w_we_idx    = r_idx;
        w_issue     = 1'b0;
        w_rd_idx    = r_idx;
        w_err_inc   = 2'd0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_err_inc  = {1'b0, w_bc_bad} + {1'b0, avm_read & avm_write};
                    w_idx_nxt  = w_cmd_idx + c_IDX_ONE;
                    w_left_nxt = w_len - c_LEN_ONE;
                    // A simultaneous read+write executes as a write only.
                    if (avm_write) begin
                        w_we     = 1'b1;
                        w_we_idx = w_cmd_idx;
                        if (w_len != c_LEN_ONE) w_state_nxt = c_ST_WR_BURST;
                    end else begin
                        w_issue  = 1'b1;
                        w_rd_idx = w_cmd_idx;
                        if (w_len != c_LEN_ONE) w_state_nxt = c_ST_RD_ISSUE;
                    end
                end
            end
            c_ST_WR_BURST: begin
                if (avm_read) w_err_inc = 2'd1;
                if (avm_write && !w_wait) begin
                    w_we       = 1'b1;
                    w_idx_nxt  = r_idx + c_IDX_ONE;
                    w_left_nxt = r_left - c_LEN_ONE;
                    if (r_left == c_LEN_ONE) w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_RD_ISSUE: begin
                w_issue    = 1'b1;
                w_idx_nxt  = r_idx + c_IDX_ONE;
                w_left_nxt = r_left - c_LEN_ONE;
                if (r_left == c_LEN_ONE) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_idx      <= '0;
            r_left     <= '0;
            r_wr_beats <= '0;
            r_rd_beats <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_left     <= w_left_nxt;
            r_wr_beats <= sat_inc(r_wr_beats, {1'b0, w_we});
            r_rd_beats <= sat_inc(r_rd_beats, {1'b0, r_pipe_vld[RD_LAT-1]});
            r_err_cnt  <= sat_inc(r_err_cnt, w_err_inc);
        end
    end

    // Memory is sampled at issue time; the pipeline only delays the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe_dat[i] <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
            r_pipe_vld[0] <= w_issue;
            r_pipe_dat[0] <= w_issue ? w_rd_word : '0;
        end
    end

    generate
        for (genvar b = 0; b < c_NB; b++) begin : g_lane
            logic [7:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (w_we && avm_byteenable[b]) r_mem[w_we_idx] <= avm_writedata[8*b +: 8];
            end

            assign w_rd_word[8*b +: 8] = r_mem[w_rd_idx];
        end
    endgenerate

    assign avm_waitrequest   = w_wait;
    assign avm_readdatavalid = r_pipe_vld[RD_LAT-1];
    assign avm_readdata      = r_pipe_dat[RD_LAT-1];
    assign wr_beats          = r_wr_beats;
    assign rd_beats          = r_rd_beats;
    assign err_cnt           = r_err_cnt;

    assign w_unused = ^{w_lfsr[15:1], avm_address, stall_en};

endmodule
`default_nettype wire

// File: tb/tb_avmm_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_avmm_mem_responder
// Brief   : Directed self-checking bench for avmm_mem_responder (RD_LAT 2 and 3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_avmm_mem_responder;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] avm_address = '0;
    logic          avm_read = 1'b0;
    logic          avm_write = 1'b0;
    logic [DW-1:0] avm_writedata = '0;
    logic [3:0]    avm_byteenable = 4'hF;
    logic [BW-1:0] avm_burstcount = 3'd1;
    logic          stall_en = 1'b0;

    logic          a_wait, a_rvld, b_wait, b_rvld;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [15:0]   a_wrb, a_rdb, a_err, b_wrb, b_rdb, b_err;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [15:0]   m_lfsr;
    logic          mon_en = 1'b0;
    logic [31:0]   m_mem [1024];

    always #5 clk = ~clk;

    avmm_mem_responder #(
        .AW(AW), .DW(DW), .MAX_BURST(4), .DEPTH(1024), .RD_LAT(2),
        .WAIT_MODE(1), .LFSR_SEED(16'hACE1)
    ) u_dut (
        .clk(clk), .rst(rst), .avm_address(avm_address), .avm_read(avm_read),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(a_wait), .avm_readdata(a_rdata), .avm_readdatavalid(a_rvld),
        .stall_en(stall_en), .wr_beats(a_wrb), .rd_beats(a_rdb), .err_cnt(a_err)
    );

    avmm_mem_responder #(
        .AW(AW), .DW(DW), .MAX_BURST(4), .DEPTH(1024), .RD_LAT(3),
        .WAIT_MODE(1), .LFSR_SEED(16'hACE1)
    ) u_dut3 (
        .clk(clk), .rst(rst), .avm_address(avm_address), .avm_read(avm_read),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(b_wait), .avm_readdata(b_rdata), .avm_readdatavalid(b_rvld),
        .stall_en(stall_en), .wr_beats(b_wrb), .rd_beats(b_rdb), .err_cnt(b_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Reference stall LFSR: taps 16,14,13,11, reset to ACE1.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    always @(posedge clk) begin
        #2;
        if (mon_en) check("wait_lfsr", 32'(a_wait), 32'(stall_en & m_lfsr[0]));
    end

    task automatic wait_accept();
        int g;
        g = 0;
        while (a_wait && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: waitrequest high for %0d cycles, expected a low cycle", g);
        end
        @(posedge clk); #1;
    endtask

    task automatic wr_single(input logic [9:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic rw);
        avm_address    = a;
        avm_writedata  = d;
        avm_byteenable = be;
        avm_burstcount = 3'd1;
        avm_write      = 1'b1;
        avm_read       = rw;
        wait_accept();
        avm_write = 1'b0;
        avm_read  = 1'b0;
    endtask

    task automatic rd_single(input logic [9:0] a, input logic [2:0] bc,
                             output logic [31:0] d, output int nv, output int lat);
        avm_address    = a;
        avm_burstcount = bc;
        avm_read       = 1'b1;
        wait_accept();
        avm_read       = 1'b0;
        avm_burstcount = 3'd1;
        nv = 0; lat = 0; d = '0;
        for (int c = 1; c <= 6; c++) begin
            if (a_rvld) begin
                if (nv == 0) begin
                    d   = a_rdata;
                    lat = c;
                end
                nv++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [9:0]  a;
        int          nv, lat, cnt;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wait", 32'(a_wait), 32'd1);
        check("rst_wait3", 32'(b_wait), 32'd1);
        check("rst_rvld", 32'(a_rvld), 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_wrb", 32'(a_wrb), 32'd0);
        check("rst_rdb", 32'(a_rdb), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_wait", 32'(a_wait), 32'd0);

        // Single write then read
        wr_single(10'h012, 32'hDEADBEEF, 4'hF, 1'b0);
        rd_single(10'h012, 3'd1, d, nv, lat);
        check("sw_data", d, 32'hDEADBEEF);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_nvalid", 32'(nv), 32'd1);
        check("sw_wrb", 32'(a_wrb), 32'd1);
        check("sw_rdb", 32'(a_rdb), 32'd1);
        check("sw_rdb3", 32'(b_rdb), 32'd1);

        // Byte enables
        wr_single(10'h005, 32'h11223344, 4'hF, 1'b0);
        wr_single(10'h005, 32'hAABBCCDD, 4'b0101, 1'b0);
        rd_single(10'h005, 3'd1, d, nv, lat);
        check("be_data", d, 32'h11BB33DD);

        // Burst write with wrap
        avm_address    = 10'h3FE;
        avm_burstcount = 3'd4;
        avm_byteenable = 4'hF;
        avm_write      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            avm_writedata = 32'(i + 1);
            wait_accept();
        end
        avm_write      = 1'b0;
        avm_burstcount = 3'd1;
        check("bw_wrb", 32'(a_wrb), 32'd7);
        for (int i = 0; i < 4; i++) begin
            a = 10'h3FE + 10'(i);
            rd_single(a, 3'd1, d, nv, lat);
            check("bw_readback", d, 32'(i + 1));
        end

        // Burst read: 3 waitrequest cycles, 4 back-to-back valids
        avm_address    = 10'h3FE;
        avm_burstcount = 3'd4;
        avm_read       = 1'b1;
        wait_accept();
        avm_read       = 1'b0;
        avm_burstcount = 3'd1;
        for (int c = 1; c <= 6; c++) begin
            if (c <= 3) check("br_wait", 32'(a_wait), 32'd1);
            if (c == 4) check("br_wait_end", 32'(a_wait), 32'd0);
            check("br_vld", 32'(a_rvld), 32'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) check("br_data", a_rdata, 32'(c - 1));
            @(posedge clk); #1;
        end
        check("br_rdb", 32'(a_rdb), 32'd10);

        // Protocol errors
        rd_single(10'h012, 3'd0, d, nv, lat);
        check("bc0_nvalid", 32'(nv), 32'd1);
        check("bc0_data", d, 32'hDEADBEEF);
        check("bc0_err", 32'(a_err), 32'd1);
        wr_single(10'h020, 32'h55AA55AA, 4'hF, 1'b1);
        cnt = 0;
        repeat (6) begin
            if (a_rvld) cnt++;
            @(posedge clk); #1;
        end
        check("rw_no_rvld", 32'(cnt), 32'd0);
        check("rw_err", 32'(a_err), 32'd2);
        rd_single(10'h020, 3'd1, d, nv, lat);
        check("rw_data", d, 32'h55AA55AA);
        rd_single(10'h012, 3'd5, d, nv, lat);
        check("bc5_nvalid", 32'(nv), 32'd1);
        check("bc5_err", 32'(a_err), 32'd3);
        check("cnt_wrb", 32'(a_wrb), 32'd8);
        check("cnt_rdb", 32'(a_rdb), 32'd13);
        check("cnt_rdb3", 32'(b_rdb), 32'd13);
        check("cnt_err3", 32'(b_err), 32'd3);

        // Reset one cycle after a 4-beat read is accepted
        avm_address    = 10'h3FE;
        avm_burstcount = 3'd4;
        avm_read       = 1'b1;
        wait_accept();
        avm_read       = 1'b0;
        avm_burstcount = 3'd1;
        rst = 1'b1;
        #1;
        check("mrst_wait_a", 32'(a_wait), 32'd1);
        @(posedge clk); #1;
        check("mrst_wait_b", 32'(b_wait), 32'd1);
        check("mrst_rvld3", 32'(b_rvld), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_rdb3", 32'(b_rdb), 32'd0);
        check("mrst_wrb", 32'(a_wrb), 32'd0);
        check("mrst_err", 32'(a_err), 32'd0);
        cnt = 0;
        repeat (8) begin
            if (a_rvld || b_rvld) cnt++;
            @(posedge clk); #1;
        end
        check("mrst_no_rvld", 32'(cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            a = 10'h3FE + 10'(i);
            rd_single(a, 3'd1, d, nv, lat);
            check("mrst_mem", d, 32'(i + 1));
        end

        // No stalls in IDLE with stall_en low
        cnt = 0;
        repeat (20) begin
            if (a_wait) cnt++;
            @(posedge clk); #1;
        end
        check("nostall_wait", 32'(cnt), 32'd0);

        // LFSR stalls: waitrequest tracks the model, random writes read back
        stall_en = 1'b1;
        mon_en   = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        for (int i = 0; i < 1000; i++) begin
            a = 10'($urandom_range(0, 1023));
            m_mem[a] = $urandom;
            wr_single(a, m_mem[a], 4'hF, 1'b0);
            rd_single(a, 3'd1, d, nv, lat);
            check("rand_data", d, m_mem[a]);
        end
        mon_en   = 1'b0;
        stall_en = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
